mdu_iter: RTL and testbench



---
 rtl/mdu_iter_pkg.sv | 44 ++++
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_iter_step.sv | 30 +++
 rtl/mdu_iter.sv | 125 ++++++++++++
 tb/tb_mdu_iter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mdu_iter_pkg.sv
// Purpose: shared types and constants for the iterative RV32M multiply/divide unit.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package m_types;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } m_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // rs1 is treated as two's complement for these ops
    function automatic logic a_is_signed(input m_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as two's complement for these ops
    function automatic logic b_is_signed(input m_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div_op(input m_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem_op(input m_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Purpose: EX-stage handshake bundle between pipeline control and the M unit.
// Latency: n/a (wires only).
// Backpressure: ready low freezes the pipeline; advance/kill come from ID/EX control.
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            advance;
    logic            kill;
    logic            ready;
    logic            busy;
    logic [XLEN-1:0] m_out;

    modport master (
        output start, op, a, b, advance, kill,
        input  ready, busy, m_out
    );

    modport slave (
        input  start, op, a, b, advance, kill,
        output ready, busy, m_out
    );
endinterface

// File: rtl/mdu_iter_step.sv
// Purpose: one combinational iteration: shift-add multiply or restoring-divide step.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next
);
    // Multiply: acc = {partial_hi, remaining multiplier bits}; add then shift right.
    // Divide:   acc = {remainder, dividend/quotient bits}; shift left, trial subtract.
    logic [XLEN:0] sum;
    logic [XLEN:0] trial;

    // Single iteration of the selected algorithm
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        acc_next = {sum, acc[XLEN-1:1]};
        if (is_div) begin
            if (trial[XLEN]) begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end else begin
                acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// Purpose: iterative RV32M multiply/divide unit with IDLE/BUSY/DONE control.
// Latency: result in cycle 33 after start (cycle 1 for divide-by-zero / overflow).
// Backpressure: ready stays low from start until DONE; DONE holds until advance or kill.
module mdu_iter
    import m_types::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_iter_if.slave  io
);
    localparam int CW = $clog2(STEPS);

    mdu_state_t        state, state_nxt;
    m_op_t             op_q;
    logic              neg_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   m_out_q;

    m_op_t             op_in;
    logic              a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic              last_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div   (is_div_op(op_q)),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    // Operand decode: magnitudes, result sign and the two short-circuit cases
    always_comb begin
        op_in    = m_op_t'(io.op);
        a_neg    = a_is_signed(op_in) & io.a[XLEN-1];
        b_neg    = b_is_signed(op_in) & io.b[XLEN-1];
        a_mag    = a_neg ? -io.a : io.a;
        b_mag    = b_neg ? -io.b : io.b;
        // Remainder follows the dividend; everything else follows the sign product
        neg_in   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div_op(op_in) && (io.b == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (io.a == INT_MIN) && (io.b == '1);
        special  = div_zero | div_ovf;
        if (is_rem_op(op_in)) begin
            special_res = div_zero ? io.a : '0;
        end else begin
            special_res = div_zero ? DIV0_QUOT : INT_MIN;
        end
    end

    // Sign fix on the final iteration's output, then pick the architectural half
    always_comb begin
        last_step = (cnt == CW'(STEPS - 1));
        prod_fix  = neg_q ? -acc_next : acc_next;
        quo_fix   = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix   = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quo_fix;
            default:                      final_res = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: kill overrides everything, DONE waits for the pipeline to advance
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (io.start) state_nxt = special ? ST_DONE : ST_BUSY;
            ST_BUSY: if (last_step) state_nxt = ST_DONE;
            ST_DONE: if (io.advance) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (io.kill) state_nxt = ST_IDLE;
    end

    // Datapath: latch operands on accept, iterate while busy, load result on finish
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            m_out_q <= '0;
        end else if (!io.kill) begin
            if (state == ST_IDLE && io.start) begin
                op_q  <= op_in;
                neg_q <= neg_in;
                cnt   <= '0;
                // Divide iterates on the dividend; multiply shifts out the multiplier
                acc   <= {{XLEN{1'b0}}, is_div_op(op_in) ? a_mag : b_mag};
                opnd  <= is_div_op(op_in) ? b_mag : a_mag;
                if (special) m_out_q <= special_res;
            end else if (state == ST_BUSY) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                if (last_step) m_out_q <= final_res;
            end
        end
    end

    assign io.ready = ((state == ST_IDLE) && !io.start) || (state == ST_DONE);
    assign io.busy  = (state == ST_BUSY);
    assign io.m_out = m_out_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Purpose: self-checking bench for mdu_iter against an arithmetic reference model.
// Latency: checks 33-cycle iterations and 1-cycle short-circuit results.
// Backpressure: exercises ready, DONE hold under start, kill and mid-op reset.
module tb_mdu_iter;
    import m_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(32)) bus ();

    mdu_iter #(.XLEN(32), .STEPS(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_res;

    // RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_m(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        r  = '0;
        case (o)
            3'd0: begin r = sx * sy; return r[31:0];  end
            3'd1: begin r = sx * sy; return r[63:32]; end
            3'd2: begin r = sx * uy; return r[63:32]; end
            3'd3: begin r = ux * uy; return r[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sx / sy; return r[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                r = ux / uy; return r[31:0];
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                r = sx % sy; return r[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                r = ux % uy; return r[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o >= 3'd4 && y == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one M-op, time it, check the result, optionally hold in DONE, then advance
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [31:0] exp;
        int          lat;
        int          cyc;
        exp = ref_m(o, x, y);
        lat = ref_lat(o, x, y);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        check("ready_cycle0", 32'(bus.ready), 32'd0);
        cyc = 0;
        while (bus.ready !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) check("busy_cycle1", 32'(bus.busy), (lat == 1) ? 32'd0 : 32'd1);
        end
        check("latency", 32'(cyc), 32'(lat));
        check("m_out", bus.m_out, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_ready", 32'(bus.ready), 32'd1);
            check("hold_busy", 32'(bus.busy), 32'd0);
            check("hold_m_out", bus.m_out, exp);
        end
        bus.advance = 1'b1;
        bus.start   = 1'b0;
        @(posedge clk); #1;
        bus.advance = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.ready), 32'd1);
        check("idle_busy", 32'(bus.busy), 32'd0);
        last_res = exp;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x, y;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        bus.advance = 1'b0; bus.kill = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_m_out", bus.m_out, 32'd0);

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);
        run_op(3'd4, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Kill in BUSY cycle 10: nothing produced, old result kept
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd9;
        repeat (10) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(negedge clk);
        check("kill_busy_before", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        bus.kill = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("kill_ready", 32'(bus.ready), 32'd1);
        check("kill_busy", 32'(bus.busy), 32'd0);
        check("kill_m_out", bus.m_out, last_res);
        run_op(3'd0, 32'd2, 32'd3, 0);

        // DONE must not restart while start stays high
        run_op(3'd5, 32'd1000, 32'd7, 5);

        // Reset in BUSY cycle 20 clears everything
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd1000; bus.b = 32'd7;
        repeat (20) @(posedge clk);
        #1; rst = 1'b1; bus.start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_m_out", bus.m_out, 32'd0);

        // Random operations with biased corner operands
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(o, x, y, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
